// File: rtl/vbuf_ptr_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the frame-buffer pointer ring.
package vbuf_ptr_pkg;

  localparam int unsigned NBUF_MAX   = 32;
  localparam int unsigned SEL_LOWEST = 0;
  localparam int unsigned SEL_OLDEST = 1;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Isolate the lowest set bit; callers zero-extend narrower masks to NBUF_MAX.
  function automatic logic [NBUF_MAX-1:0] onehot_lowest(input logic [NBUF_MAX-1:0] vec);
    return vec & (~vec + NBUF_MAX'(1));
  endfunction

endpackage

// File: rtl/vbuf_pick.sv
// Combinational buffer chooser: lowest-index free buffer, or the free buffer with the largest age.
module vbuf_pick #(
  parameter int unsigned NBUF     = 5,
  parameter int unsigned AW       = 4,
  parameter int unsigned SEL_MODE = 0
) (
  input  logic [NBUF-1:0]    free,
  input  logic [NBUF*AW-1:0] ages,
  output logic [NBUF-1:0]    choice
);
  import vbuf_ptr_pkg::*;

  if (SEL_MODE == SEL_OLDEST) begin : g_oldest
    // Strictly-greater compare keeps the lowest index on equal ages.
    always_comb begin
      logic          found;
      logic [AW-1:0] best_age;
      choice   = '0;
      found    = 1'b0;
      best_age = '0;
      for (int i = 0; i < NBUF; i++) begin
        if (free[i] && (!found || (ages[i*AW +: AW] > best_age))) begin
          choice    = '0;
          choice[i] = 1'b1;
          found     = 1'b1;
          best_age  = ages[i*AW +: AW];
        end
      end
    end
  end else begin : g_lowest
    logic [NBUF_MAX-1:0] low;
    logic                unused;
    assign low    = onehot_lowest(NBUF_MAX'(free));
    assign choice = low[NBUF-1:0];
    assign unused = ^{ages, low};
  end

endmodule

// File: rtl/vbuf_ptr_ring.sv
// Frame-buffer pointer manager: one writer, NRD readers, NBUF one-hot buffers, all in the wclk domain.
// Optional drop counter and drop_cnt port are built when VBUF_DROP_CNT_EN is defined.
module vbuf_ptr_ring #(
  parameter int unsigned NBUF     = 5,
  parameter int unsigned NRD      = 3,
  parameter int unsigned SEL_MODE = 0
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                wr_vs,
  input  logic [NRD*NBUF-1:0] rd_curr_point,
  output logic [NBUF-1:0]     wr_current_point,
  output logic [NBUF-1:0]     last_done_point,
  output logic                last_done_valid,
  output logic                wr_hold,
  output logic                frame_drop
`ifdef VBUF_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);
  import vbuf_ptr_pkg::*;

  localparam int unsigned     AW      = $clog2(NBUF) + 1;
  localparam logic [AW-1:0]   AGE_MAX = AW'(NBUF);
  localparam logic [NBUF-1:0] BUF0    = NBUF'(1);

  logic                vs_q;
  logic                rise;
  logic [NBUF-1:0]     free_q;
  logic [NBUF-1:0]     rd_any;
  logic [NBUF-1:0]     choice;
  logic [NBUF*AW-1:0]  ages;
  state_t              state, state_d;
  logic                commit, drop;

  assign rise = wr_vs & ~vs_q;

  // Reader pointers are merged as-is, so malformed multi-bit values simply block more buffers.
  always_comb begin
    rd_any = '0;
    for (int i = 0; i < NRD; i++) rd_any |= rd_curr_point[i*NBUF +: NBUF];
  end

  vbuf_pick #(
    .NBUF     (NBUF),
    .AW       (AW),
    .SEL_MODE (SEL_MODE)
  ) u_pick (
    .free   (free_q),
    .ages   (ages),
    .choice (choice)
  );

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state <= ST_INIT;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    commit  = 1'b0;
    drop    = 1'b0;
    if (rise) begin
      if (|free_q) begin
        commit  = 1'b1;
        state_d = ST_RUN;
      end else begin
        drop    = 1'b1;
        state_d = ST_HOLD;
      end
    end
  end

  // Free mask resets to "all but buffer 0" so the first boundary after reset can commit.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      vs_q             <= 1'b0;
      free_q           <= ~BUF0;
      wr_current_point <= BUF0;
      last_done_point  <= '0;
      last_done_valid  <= 1'b0;
      wr_hold          <= 1'b0;
      frame_drop       <= 1'b0;
    end else begin
      vs_q       <= wr_vs;
      free_q     <= ~(wr_current_point | rd_any);
      frame_drop <= drop;
      wr_hold    <= (state_d == ST_HOLD);
      if (commit) begin
        wr_current_point <= choice;
        last_done_point  <= wr_current_point;
        last_done_valid  <= 1'b1;
      end
    end
  end

  // Ages count commits since a buffer was last written, saturating at NBUF.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      ages <= '0;
    end else if (commit) begin
      for (int i = 0; i < NBUF; i++) begin
        if (wr_current_point[i])                ages[i*AW +: AW] <= '0;
        else if (ages[i*AW +: AW] != AGE_MAX)   ages[i*AW +: AW] <= ages[i*AW +: AW] + AW'(1);
      end
    end
  end

`ifdef VBUF_DROP_CNT_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)                            drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vbuf_ptr_ring.sv
// Bench for vbuf_ptr_ring: two instances (5 buf/3 rd lowest-first, 4 buf/2 rd oldest-first) against a reference model.
module tb_vbuf_ptr_ring;

  localparam int NA = 5, RA = 3, NB = 4, RB = 2;

  logic            wclk = 1'b0;
  logic            wrst = 1'b1;
  logic            wr_vs = 1'b0;
  logic [RA*NA-1:0] rd_a = '0;
  logic [RB*NB-1:0] rd_b = '0;
  logic [NA-1:0]   wa, la;
  logic [NB-1:0]   wb, lb;
  logic            va, ha, fa, vb, hb, fb;
`ifdef VBUF_DROP_CNT_EN
  logic [15:0]     ca, cb;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 wclk = ~wclk;

  vbuf_ptr_ring #(.NBUF(NA), .NRD(RA), .SEL_MODE(0)) u_dut_a (
    .wclk(wclk), .wrst(wrst), .wr_vs(wr_vs), .rd_curr_point(rd_a),
    .wr_current_point(wa), .last_done_point(la), .last_done_valid(va),
    .wr_hold(ha), .frame_drop(fa)
`ifdef VBUF_DROP_CNT_EN
    , .drop_cnt(ca)
`endif
  );

  vbuf_ptr_ring #(.NBUF(NB), .NRD(RB), .SEL_MODE(1)) u_dut_b (
    .wclk(wclk), .wrst(wrst), .wr_vs(wr_vs), .rd_curr_point(rd_b),
    .wr_current_point(wb), .last_done_point(lb), .last_done_valid(vb),
    .wr_hold(hb), .frame_drop(fb)
`ifdef VBUF_DROP_CNT_EN
    , .drop_cnt(cb)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer indices as ints, free set as a bitmask, ages per buffer.
  int          m_wr[2], m_last[2], m_cnt[2];
  bit          m_valid[2], m_hold[2], m_drop[2], m_vsp[2];
  bit [31:0]   m_free[2];
  int          m_age[2][32];

  task automatic m_reset(input int k, input int n);
    m_wr[k] = 0; m_last[k] = -1; m_cnt[k] = 0;
    m_valid[k] = 0; m_hold[k] = 0; m_drop[k] = 0; m_vsp[k] = 0;
    m_free[k] = ((32'd1 << n) - 32'd1) & ~32'd1;
    for (int i = 0; i < 32; i++) m_age[k][i] = 0;
  endtask

  task automatic m_step(input int k, input int n, input int mode, input bit vs, input bit [31:0] rd_or);
    bit [31:0] nf;
    int        pick;
    nf = ~((32'd1 << m_wr[k]) | rd_or) & ((32'd1 << n) - 32'd1);
    m_drop[k] = 0;
    if (vs && !m_vsp[k]) begin
      if (m_free[k] != 0) begin
        pick = -1;
        for (int i = 0; i < n; i++)
          if (m_free[k][i]) begin
            if (mode == 0) begin
              if (pick < 0) pick = i;
            end else if (pick < 0 || m_age[k][i] > m_age[k][pick]) pick = i;
          end
        for (int i = 0; i < n; i++)
          m_age[k][i] = (i == m_wr[k]) ? 0 : ((m_age[k][i] + 1 > n) ? n : m_age[k][i] + 1);
        m_last[k] = m_wr[k]; m_wr[k] = pick; m_valid[k] = 1; m_hold[k] = 0;
      end else begin
        m_drop[k] = 1; m_hold[k] = 1;
        if (m_cnt[k] < 65535) m_cnt[k]++;
      end
    end
    m_free[k] = nf;
    m_vsp[k]  = vs;
  endtask

  always @(posedge wclk or posedge wrst) begin : model
    bit [31:0] oa, ob;
    if (wrst) begin
      m_reset(0, NA);
      m_reset(1, NB);
    end else begin
      oa = '0; ob = '0;
      for (int r = 0; r < RA; r++) oa |= 32'(rd_a[r*NA +: NA]);
      for (int r = 0; r < RB; r++) ob |= 32'(rd_b[r*NB +: NB]);
      m_step(0, NA, 0, wr_vs, oa);
      m_step(1, NB, 1, wr_vs, ob);
    end
  end

  function automatic logic [31:0] ptr_of(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  always @(negedge wclk) begin
    if (chk_en) begin
      check("a_wr",    32'(wa), ptr_of(m_wr[0]));
      check("a_last",  32'(la), ptr_of(m_last[0]));
      check("a_valid", 32'(va), 32'(m_valid[0]));
      check("a_hold",  32'(ha), 32'(m_hold[0]));
      check("a_drop",  32'(fa), 32'(m_drop[0]));
      check("b_wr",    32'(wb), ptr_of(m_wr[1]));
      check("b_last",  32'(lb), ptr_of(m_last[1]));
      check("b_valid", 32'(vb), 32'(m_valid[1]));
      check("b_hold",  32'(hb), 32'(m_hold[1]));
      check("b_drop",  32'(fb), 32'(m_drop[1]));
`ifdef VBUF_DROP_CNT_EN
      check("a_cnt",   32'(ca), 32'(m_cnt[0]));
      check("b_cnt",   32'(cb), 32'(m_cnt[1]));
`endif
    end
  end

  // Raise wr_vs; returns at the negedge after the commit edge.
  task automatic vs_pulse();
    @(posedge wclk); #1 wr_vs = 1'b1;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic vs_release();
    @(posedge wclk); #1 wr_vs = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
  endtask

  function automatic logic [31:0] rnd_ptr(input int n);
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'd0;
      1, 2:    v = 32'd1 << $urandom_range(0, n - 1);
      default: v = $urandom & ((32'd1 << n) - 32'd1);
    endcase
    return v;
  endfunction

  int exp_a[6] = '{2, 1, 2, 1, 2, 1};
  int exp_b[6] = '{2, 4, 8, 1, 2, 4};

  initial begin
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    check("rst_wr",    32'(wa), 32'h1);
    check("rst_last",  32'(la), 32'h0);
    check("rst_valid", 32'(va), 32'h0);
    check("rst_hold",  32'(ha), 32'h0);
    check("rst_drop",  32'(fa), 32'h0);
    chk_en = 1'b1;
    @(posedge wclk); #1 wrst = 1'b0;

    // Lowest-first ping-pong on A and oldest-first rotation on B, no readers.
    for (int j = 0; j < 6; j++) begin
      vs_pulse();
      check("t1_a_wr", 32'(wa), 32'(exp_a[j]));
      check("t4_b_wr", 32'(wb), 32'(exp_b[j]));
      if (j == 0) check("t1_a_valid", 32'(va), 32'h1);
      vs_release();
    end

    @(posedge wclk); #1 rd_a = {5'b01000, 5'b00100, 5'b00010};
    vs_pulse();
    check("t2_wr",   32'(wa), 32'h10);
    check("t2_last", 32'(la), 32'h01);
    vs_release();

    @(posedge wclk); #1 rd_a = {5'b01001, 5'b00100, 5'b00010};
    vs_pulse();
    check("t3_drop", 32'(fa), 32'h1);
    check("t3_hold", 32'(ha), 32'h1);
    check("t3_wr",   32'(wa), 32'h10);
    check("t3_last", 32'(la), 32'h01);
`ifdef VBUF_DROP_CNT_EN
    check("t3_cnt",  32'(ca), 32'h1);
`endif
    vs_release();
    check("t3_pulse_end", 32'(fa), 32'h0);
    @(posedge wclk); #1 rd_a = {5'b01001, 5'b00000, 5'b00010};
    vs_pulse();
    check("t3_rel_wr",   32'(wa), 32'h04);
    check("t3_rel_hold", 32'(ha), 32'h0);
    vs_release();

    @(posedge wclk); #1 rd_a = {5'b11011, 5'b00000, 5'b00000};
    vs_pulse();
    check("t5_hold", 32'(ha), 32'h1);
    vs_release();
    @(posedge wclk); #1 wrst = 1'b1;
    #1;
    check("t5_rst_wr",    32'(wa), 32'h1);
    check("t5_rst_last",  32'(la), 32'h0);
    check("t5_rst_valid", 32'(va), 32'h0);
    check("t5_rst_hold",  32'(ha), 32'h0);
    rd_a = '0;
    @(posedge wclk); #1 wrst = 1'b0;
    vs_pulse();
    check("t5_wr",    32'(wa), 32'h02);
    check("t5_last",  32'(la), 32'h01);
    check("t5_valid", 32'(va), 32'h1);
    vs_release();

    // Random readers, random vsync timing, occasional reset.
    for (int it = 0; it < 250; it++) begin
      for (int r = 0; r < RA; r++) rd_a[r*NA +: NA] = NA'(rnd_ptr(NA));
      for (int r = 0; r < RB; r++) rd_b[r*NB +: NB] = NB'(rnd_ptr(NB));
      repeat ($urandom_range(1, 3)) @(posedge wclk);
      #1 wr_vs = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge wclk);
      #1 wr_vs = 1'b0;
      if (it % 61 == 30) begin
        @(posedge wclk); #1 wrst = 1'b1;
        @(posedge wclk); #1 wrst = 1'b0;
      end
    end

    repeat (3) @(posedge wclk);
    @(negedge wclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
